mem_test_initiator: RTL and testbench
=====================================

// Module: mem_test_initiator
// PURPOSE
// - Hardware initiator for the single-port memory bus (addr/wr_en/rd_en/wdata/rdata).
// - On start: writes a pattern to every location, reads everything back and compares each word.
// - Reports pass/fail, an error count and the first failing address.
// - Sits in front of the memory as the bus master. It replaces the bench driver for self-test.
// PARAMETERS
// - ADDR_W   4   address width
// - DATA_W   8   data width
// - DEPTH    16  locations tested, 0..DEPTH-1; 2 <= DEPTH <= 2**ADDR_W
// - RD_LAT   1   cycles from rd_en high to valid rdata; range 1..4
// PORTS
// - clk        in   1       clock; all logic on rising edge
// - reset      in   1       synchronous, active-high
// - start      in   1       1-cycle request; ignored while busy
// - pat_sel    in   1       0: wdata = {addr}^seed; 1: checkerboard (seed / ~seed by addr[0])
// - seed       in   DATA_W  pattern seed; sampled on accepted start
// - addr       out  ADDR_W  memory address
// - wr_en      out  1       memory write strobe
// - rd_en      out  1       memory read strobe
// - wdata      out  DATA_W  memory write data
// - rdata      in   DATA_W  memory read data, valid RD_LAT cycles after rd_en
// - busy       out  1       high from accepted start until done
// - done       out  1       1-cycle pulse at end of test
// - pass       out  1       valid from done until the next start; 1 = zero mismatches
// - err_cnt    out  8       mismatch count, saturates at 255
// - fail_addr  out  ADDR_W  address of first mismatch; 0 if none
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, counters 0. Takes effect even mid-test. No done pulse is produced.
// - FSM states: IDLE -> WRITE -> READ -> DRAIN -> DONE -> IDLE.
// - IDLE:
//   - start=1 latches pat_sel and seed.
//   - Clears err_cnt, fail_addr and pass.
//   - Sets busy. Next state WRITE.
// - WRITE:
//   - Asserts wr_en for DEPTH consecutive cycles, addr 0..DEPTH-1.
//   - wdata is the pattern of that addr.
//   - Pattern 0 zero-extends or truncates addr to DATA_W before XOR with seed.
//   - After addr=DEPTH-1: addr returns to 0, next state READ. No idle cycle.
// - READ:
//   - Asserts rd_en for DEPTH consecutive cycles, addr 0..DEPTH-1.
//   - Pushes {expected, addr} into an RD_LAT-deep valid pipeline.
// - Compare: pipeline output valid -> compare rdata with expected.
//   - On mismatch, err_cnt increments (saturating).
//   - On the first mismatch only, fail_addr captures that address.
// - DRAIN: no strobes. Waits RD_LAT cycles until the pipeline is empty.
// - DONE: one cycle. done=1; pass = (err_cnt==0); busy drops the same cycle.
// - Bus rules:
//   - wr_en and rd_en are never high together.
//   - addr and wdata are 0 whenever both strobes are low.
// - Latency: done occurs exactly 2*DEPTH + RD_LAT + 2 cycles after the accepted start edge.
// - start during busy: ignored. start in the DONE cycle: ignored. Accepted from IDLE only.
// - DEPTH < 2**ADDR_W: addresses >= DEPTH are never driven.
// CONFIGURATION
// - MEM_TEST_INV_PASS_EN defined:
//   - After the first READ, runs a second WRITE/READ/DRAIN pass with inverted patterns (~pattern).
//   - Errors from both passes accumulate. fail_addr is the first mismatch overall.
//   - Latency becomes 4*DEPTH + 2*RD_LAT + 3.
// - MEM_TEST_INV_PASS_EN undefined: single pass only. Inverted-pass logic is absent.
// TESTING
// - Reset 2 cycles, start with pat_sel=0, seed=8'h00, ideal memory:
//   - wr_en high 16 cycles, addr 0..15, wdata 0..15.
//   - Then 16 rd_en cycles.
//   - done at cycle 35; pass=1, err_cnt=0.
// - pat_sel=1, seed=8'hA5:
//   - wdata alternates A5,5A,... by addr.
//   - pass=1. wr_en and rd_en never both high.
// - Memory model forces bit0 stuck-at-1 at addr 5 and 9:
//   - err_cnt=2, fail_addr=5, pass=0.
// - Memory forced to return 8'hFF on every read, seed=8'h00:
//   - 16 mismatches, err_cnt=16.
//   - Re-start clears err_cnt=0 before the new test.
// - start pulsed again at cycle 10 of a test:
//   - Ignored; done still at cycle 35.
//   - reset asserted at cycle 20: all outputs 0 next cycle, no done pulse.
// - With MEM_TEST_INV_PASS_EN, seed=8'h0F:
//   - Second pass writes ~(addr^0F).
//   - done at cycle 69 (DEPTH=16, RD_LAT=1); pass=1.

Source files
------------

// File: rtl/mem_test_initiator.sv
`default_nettype none
// ============================================================================
// Module      : mem_test_initiator
// Description : Self-test bus master for a single-port memory. It writes a
//               pattern to every location and then reads each one back. It
//               compares every word it reads and reports pass/fail, a
//               saturating error count and the first failing address.
//               Optional macro MEM_TEST_INV_PASS_EN adds a second
//               write/read pass that uses the inverted pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_test_initiator #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pat_sel,
    input  logic [DATA_W-1:0] seed,
    output logic [ADDR_W-1:0] addr,
    output logic              wr_en,
    output logic              rd_en,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_cnt,
    output logic [ADDR_W-1:0] fail_addr
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Last address of a sweep, and the final drain count. The drain covers
    // the read latency plus the compare register, which lets the verdict
    // see the last error-count update.
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);
    localparam logic [2:0]        c_drn_last  = 3'(RD_LAT + 1);
`ifdef MEM_TEST_INV_PASS_EN
    // Gap between the normal pass and the inverted pass.
    localparam logic [2:0]        c_drn_mid   = 3'(RD_LAT);
`endif

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [2:0]          drn_q, drn_d;
    logic                pat_q, pat_d;
    logic [DATA_W-1:0]   seed_q, seed_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                w_accept;
`ifdef MEM_TEST_INV_PASS_EN
    logic                inv_q, inv_d;
`endif

    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_en_q, wr_en_d;
    logic                rd_en_q, rd_en_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   exp_q, exp_d;
    logic [DATA_W-1:0]   w_cur_pat;

    logic                pv_q [RD_LAT];
    logic                pv_d [RD_LAT];
    logic [DATA_W-1:0]   pe_q [RD_LAT];
    logic [DATA_W-1:0]   pe_d [RD_LAT];
    logic [ADDR_W-1:0]   pa_q [RD_LAT];
    logic [ADDR_W-1:0]   pa_d [RD_LAT];

    logic [7:0]          err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
    logic                w_mismatch;

    // The base pattern for one address: the address XOR the seed, or a
    // checkerboard of seed and ~seed.
    function automatic logic [DATA_W-1:0] pattern_of(
        input logic [ADDR_W-1:0] a,
        input logic              sel,
        input logic [DATA_W-1:0] s
    );
        if (sel) begin
            return a[0] ? ~s : s;
        end
        return DATA_W'(a) ^ s;
    endfunction

`ifdef MEM_TEST_INV_PASS_EN
    assign w_cur_pat = pattern_of(cnt_q, pat_q, seed_q) ^ {DATA_W{inv_q}};
`else
    assign w_cur_pat = pattern_of(cnt_q, pat_q, seed_q);
`endif

    // All state. Reset clears it at once, even in the middle of a test.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            drn_q       <= '0;
            pat_q       <= 1'b0;
            seed_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            addr_q      <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            wdata_q     <= '0;
            exp_q       <= '0;
            err_cnt_q   <= '0;
            fail_addr_q <= '0;
`ifdef MEM_TEST_INV_PASS_EN
            inv_q       <= 1'b0;
`endif
            for (int i = 0; i < RD_LAT; i++) begin
                pv_q[i] <= 1'b0;
                pe_q[i] <= '0;
                pa_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            drn_q       <= drn_d;
            pat_q       <= pat_d;
            seed_q      <= seed_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            addr_q      <= addr_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            wdata_q     <= wdata_d;
            exp_q       <= exp_d;
            err_cnt_q   <= err_cnt_d;
            fail_addr_q <= fail_addr_d;
`ifdef MEM_TEST_INV_PASS_EN
            inv_q       <= inv_d;
`endif
            for (int i = 0; i < RD_LAT; i++) begin
                pv_q[i] <= pv_d[i];
                pe_q[i] <= pe_d[i];
                pa_q[i] <= pa_d[i];
            end
        end
    end

    // Sequencer: next state, the sweep and drain counters, and status flags.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        drn_d    = drn_q;
        pat_d    = pat_q;
        seed_d   = seed_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        w_accept = 1'b0;
`ifdef MEM_TEST_INV_PASS_EN
        inv_d    = inv_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    pat_d    = pat_sel;
                    seed_d   = seed;
                    pass_d   = 1'b0;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
`ifdef MEM_TEST_INV_PASS_EN
                    inv_d    = 1'b0;
`endif
                    state_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                if (cnt_q == c_last_addr) begin
                    cnt_d   = '0;
                    state_d = S_READ;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            S_READ: begin
                if (cnt_q == c_last_addr) begin
                    cnt_d   = '0;
                    drn_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
`ifdef MEM_TEST_INV_PASS_EN
                if (!inv_q && drn_q == c_drn_mid) begin
                    inv_d   = 1'b1;
                    drn_d   = '0;
                    state_d = S_WRITE;
                end else
`endif
                if (drn_q == c_drn_last) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = (err_cnt_q == 8'd0);
                    state_d = S_DONE;
                end else begin
                    drn_d = drn_q + 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus driver, one register stage behind the sequencer. When neither
    // strobe is active, the address and data are held at zero.
    always_comb begin
        addr_d  = '0;
        wr_en_d = 1'b0;
        rd_en_d = 1'b0;
        wdata_d = '0;
        exp_d   = '0;
        if (state_q == S_WRITE) begin
            wr_en_d = 1'b1;
            addr_d  = cnt_q;
            wdata_d = w_cur_pat;
        end else if (state_q == S_READ) begin
            rd_en_d = 1'b1;
            addr_d  = cnt_q;
            exp_d   = w_cur_pat;
        end
    end

    // Expected-data pipeline, aligned with the memory read latency, plus
    // the compare and the error bookkeeping.
    always_comb begin
        pv_d[0] = rd_en_q;
        pe_d[0] = exp_q;
        pa_d[0] = addr_q;
        for (int i = 1; i < RD_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pe_d[i] = pe_q[i-1];
            pa_d[i] = pa_q[i-1];
        end

        w_mismatch  = pv_q[RD_LAT-1] && (rdata != pe_q[RD_LAT-1]);
        err_cnt_d   = err_cnt_q;
        fail_addr_d = fail_addr_q;
        if (w_accept) begin
            err_cnt_d   = 8'd0;
            fail_addr_d = '0;
        end else if (w_mismatch) begin
            // The count never wraps, so a count of zero means this is the
            // first mismatch of the test.
            if (err_cnt_q == 8'd0) begin
                fail_addr_d = pa_q[RD_LAT-1];
            end
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    assign addr      = addr_q;
    assign wr_en     = wr_en_q;
    assign rd_en     = rd_en_q;
    assign wdata     = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_cnt   = err_cnt_q;
    assign fail_addr = fail_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_test_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_test_initiator
// Description : Directed bench for mem_test_initiator with a behavioural
//               single-port memory that can inject faults.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_test_initiator;

`ifdef MEM_TEST_INV_PASS_EN
    localparam int c_lat    = 69;
    localparam int c_nwr    = 32;
    localparam int c_ff_err = 31;
`else
    localparam int c_lat    = 35;
    localparam int c_nwr    = 16;
    localparam int c_ff_err = 16;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       pat_sel = 1'b0;
    logic [7:0] seed = 8'h00;
    logic [3:0] addr;
    logic       wr_en, rd_en;
    logic [7:0] wdata;
    logic [7:0] rdata = 8'h00;
    logic       busy, done, pass;
    logic [7:0] err_cnt;
    logic [3:0] fail_addr;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int start_cyc = 0;
    int fault   = 0;
    logic       cur_sel = 1'b0;
    logic [7:0] cur_seed = 8'h00;

    int both_hi = 0, idle_bus = 0;
    int wr_seen = 0, rd_seen = 0, wr_bad = 0, rd_bad = 0, done_seen = 0;
    logic [7:0] w1, w2;

    logic [7:0] mem [16];

    mem_test_initiator #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .RD_LAT(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pat_sel   (pat_sel),
        .seed      (seed),
        .addr      (addr),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .wdata     (wdata),
        .rdata     (rdata),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_cnt   (err_cnt),
        .fail_addr (fail_addr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory with one-cycle read latency and selectable faults.
    always @(posedge clk) begin
        if (wr_en) mem[addr] <= wdata;
        if (rd_en) begin
            case (fault)
                1:       rdata <= (addr == 4'd5 || addr == 4'd9) ? (mem[addr] | 8'h01) : mem[addr];
                2:       rdata <= 8'hFF;
                default: rdata <= mem[addr];
            endcase
        end
    end

    function automatic logic [7:0] pat_exp(input int a, input logic sel,
                                           input logic [7:0] s, input logic inv);
        logic [7:0] p;
        p = sel ? (a[0] ? ~s : s) : (8'(a) ^ s);
        return inv ? ~p : p;
    endfunction

    // Bus monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (wr_en && rd_en) both_hi++;
        if (!wr_en && !rd_en && (addr != 4'd0 || wdata != 8'd0)) idle_bus++;
        if (wr_en) begin
            if (addr != 4'(wr_seen % 16) ||
                wdata != pat_exp(wr_seen % 16, cur_sel, cur_seed, wr_seen >= 16)) wr_bad++;
            wr_seen++;
        end
        if (rd_en) begin
            if (addr != 4'(rd_seen % 16)) rd_bad++;
            rd_seen++;
        end
        if (done) done_seen++;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic start_test(input logic sel, input logic [7:0] sd, input int flt);
        @(negedge clk);
        fault = flt; cur_sel = sel; cur_seed = sd;
        wr_seen = 0; rd_seen = 0; wr_bad = 0; rd_bad = 0; done_seen = 0;
        pat_sel = sel; seed = sd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start_cyc = cyc;
    endtask

    // Wait for done; optionally re-pulse start at offset repulse_at.
    task automatic wait_done(input string tag, input int repulse_at);
        int lat;
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            start = (i == repulse_at);
            if (i == 1) w1 = wdata;
            if (i == 2) w2 = wdata;
            if (done) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
        check_val({tag, "_latency"}, lat, c_lat);
        check_val({tag, "_busy_at_done"}, busy, 0);
        @(negedge clk);
        check_val({tag, "_done_width"}, done, 0);
    endtask

    initial begin
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_val("reset_outputs", {busy, done, pass, wr_en, rd_en, addr, wdata, err_cnt, fail_addr}, 0);

        // Address pattern, seed 00, ideal memory.
        start_test(1'b0, 8'h00, 0);
        check_val("a_busy_after_start", busy, 1);
        wait_done("a", 0);
        check_val("a_wdata0", w1, 8'h00);
        check_val("a_wdata1", w2, 8'h01);
        check_val("a_pass", pass, 1);
        check_val("a_err", err_cnt, 0);
        check_val("a_fail_addr", fail_addr, 0);
        check_val("a_writes", wr_seen, c_nwr);
        check_val("a_reads", rd_seen, c_nwr);
        check_val("a_wr_bad", wr_bad, 0);
        check_val("a_rd_bad", rd_bad, 0);

        // Checkerboard, seed A5.
        start_test(1'b1, 8'hA5, 0);
        wait_done("b", 0);
        check_val("b_wdata0", w1, 8'hA5);
        check_val("b_wdata1", w2, 8'h5A);
        check_val("b_pass", pass, 1);
        check_val("b_wr_bad", wr_bad, 0);

        // Bit 0 stuck at 1 at addresses 5 and 9.
        start_test(1'b0, 8'h01, 1);
        wait_done("c", 0);
        check_val("c_err", err_cnt, 2);
        check_val("c_fail_addr", fail_addr, 5);
        check_val("c_pass", pass, 0);

        // Memory returns FF on every read.
        start_test(1'b0, 8'h00, 2);
        wait_done("d", 0);
        check_val("d_err", err_cnt, c_ff_err);
        check_val("d_fail_addr", fail_addr, 0);
        check_val("d_pass", pass, 0);
        check_val("d_pass_held", pass, 0);

        // A new start clears the previous results.
        start_test(1'b0, 8'h00, 0);
        check_val("e_err_cleared", err_cnt, 0);
        check_val("e_pass_cleared", pass, 0);
        wait_done("e", 0);
        check_val("e_pass", pass, 1);

        // A start pulse mid-test is ignored.
        start_test(1'b0, 8'h3C, 0);
        wait_done("f", 10);
        check_val("f_done_count", done_seen, 1);
        check_val("f_pass", pass, 1);

        // Reset in the middle of a test.
        start_test(1'b0, 8'h00, 0);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("g_reset_outputs", {busy, done, pass, wr_en, rd_en, addr, wdata, err_cnt, fail_addr}, 0);
        repeat (80) @(negedge clk);
        check_val("g_no_done", done_seen, 0);
        check_val("g_idle_busy", busy, 0);

        check_val("bus_both_strobes", both_hi, 0);
        check_val("bus_idle_nonzero", idle_bus, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
